dcache_ctrl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate L1 data-cache controller; sequences data_array (64x128b) + tag_array (64x22b).

---
 rtl/dcache_ctrl_pkg.sv | 21 ++
 rtl/dcache_ctrl_if.sv | 13 +
 rtl/dcache_ctrl_perf_cnt.sv | 22 ++
 rtl/dcache_ctrl.sv | 157 +++++++++++++++
 tb/tb_dcache_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg: cache geometry, FSM state type, line/tag types and address field helpers
package dcache_ctrl_pkg;
  localparam int LINES = 64;
  localparam int WORDS = 4;
  localparam int INDEX_W = $clog2(LINES);
  localparam int OFFSET_W = 4;
  localparam int TAG_W = 32 - INDEX_W - OFFSET_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, RD_MISS, REFILL, WR_MEM} dcache_state_t;
  typedef logic [WORDS-1:0][31:0] line_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [INDEX_W-1:0] idx_t;
  function automatic tag_t addr_tag(logic [31:0] a);
    return a[31:32-TAG_W];
  endfunction
  function automatic idx_t addr_idx(logic [31:0] a);
    return a[OFFSET_W +: INDEX_W];
  endfunction
  function automatic logic [1:0] addr_word(logic [31:0] a);
    return a[3:2];
  endfunction
endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if: request/response bus shared by the CPU-side and memory-side ports
// master drives req/write/addr/wstrb/wdata and receives rdata/ready; slave is the mirror.
interface dcache_ctrl_if;
  logic        req;
  logic        write;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  modport master(output req, write, addr, wstrb, wdata, input rdata, ready);
  modport slave(input req, write, addr, wstrb, wdata, output rdata, ready);
endinterface

// File: rtl/dcache_ctrl_perf_cnt.sv
// dcache_perf_cnt: saturating hit/miss event counters
// Ports: clk, rst (async, active-high); hit_i/miss_i one-cycle events; hit_o/miss_o counts.
module dcache_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_i,
  input  logic        miss_i,
  output logic [31:0] hit_o,
  output logic [31:0] miss_o
);
  logic [31:0] hit_q, miss_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      hit_q <= hit_q + 32'(hit_i && hit_q != '1);
      miss_q <= miss_q + 32'(miss_i && miss_q != '1);
    end
  assign hit_o = hit_q;
  assign miss_o = miss_q;
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-through no-write-allocate L1 data-cache controller
// Ports: clk, rst (async, active-high); core (bus slave, CPU LSU); mem (bus master, memory wrapper);
//   da_* data_array 64x128 controls (web active-low per byte); ta_* tag_array 64x22 controls.
// Option: DCACHE_PERF_EN adds perf_hit_o/perf_miss_o saturating counters.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  dcache_ctrl_if.slave         core,
  dcache_ctrl_if.master        mem,
  output logic                 da_cs_o,
  output logic                 da_oe_o,
  output logic [4*WORDS-1:0]   da_web_o,
  output idx_t                 da_a_o,
  output line_t                da_di_o,
  input  line_t                da_do_i,
  output logic                 ta_cs_o,
  output logic                 ta_oe_o,
  output logic                 ta_web_o,
  output idx_t                 ta_a_o,
  output tag_t                 ta_di_o,
  input  tag_t                 ta_do_i
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]          perf_hit_o,
  output logic [31:0]          perf_miss_o
`endif
);
  dcache_state_t state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, req_addr;
  logic [3:0] wstrb_q, wstrb_d;
  logic write_q, write_d, hit;
  logic [1:0] cnt_q, cnt_d;
  line_t buf_q, buf_d;
  assign req_addr = {addr_q, 2'b00};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      write_q <= write_d;
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    write_d = write_q;
    cnt_d = cnt_q;
    buf_d = buf_q;
    hit = valid_q[addr_idx(req_addr)] && ta_do_i == addr_tag(req_addr);
    core.ready = 1'b0;
    core.rdata = '0;
    mem.req = 1'b0;
    mem.write = 1'b0;
    mem.addr = '0;
    mem.wstrb = '0;
    mem.wdata = '0;
    da_cs_o = 1'b0;
    da_oe_o = 1'b0;
    da_web_o = '1;
    da_a_o = addr_idx(req_addr);
    da_di_o = buf_q;
    ta_cs_o = 1'b0;
    ta_oe_o = 1'b0;
    ta_web_o = 1'b1;
    ta_a_o = addr_idx(req_addr);
    ta_di_o = addr_tag(req_addr);
    case (state_q)
      IDLE: if (core.req) begin
        addr_d = core.addr[31:2];
        wdata_d = core.wdata;
        wstrb_d = core.wstrb;
        write_d = core.write;
        da_cs_o = 1'b1;
        da_oe_o = 1'b1;
        ta_cs_o = 1'b1;
        ta_oe_o = 1'b1;
        da_a_o = addr_idx(core.addr);
        ta_a_o = addr_idx(core.addr);
        state_d = LOOKUP;
      end
      LOOKUP: if (!write_q && hit) begin
        core.ready = 1'b1;
        core.rdata = da_do_i[addr_word(req_addr)];
        state_d = IDLE;
      end else if (!write_q) begin
        cnt_d = '0;
        state_d = RD_MISS;
      end else begin
        state_d = WR_MEM;
        if (hit) begin
          // write-through hit: patch only the strobed bytes of the addressed word
          da_cs_o = 1'b1;
          da_web_o = ~(16'(wstrb_q) << {addr_word(req_addr), 2'b00});
          da_di_o = {WORDS{wdata_q}};
        end
      end
      RD_MISS: begin
        mem.req = 1'b1;
        mem.addr = {req_addr[31:4], cnt_q, 2'b00};
        if (mem.ready) begin
          buf_d[cnt_q] = mem.rdata;
          cnt_d = cnt_q + 2'd1;
          state_d = cnt_q == 2'd3 ? REFILL : RD_MISS;
        end
      end
      REFILL: begin
        da_cs_o = 1'b1;
        da_web_o = '0;
        ta_cs_o = 1'b1;
        ta_web_o = 1'b0;
        valid_d[addr_idx(req_addr)] = 1'b1;
        core.ready = 1'b1;
        core.rdata = buf_q[addr_word(req_addr)];
        state_d = IDLE;
      end
      WR_MEM: begin
        mem.req = 1'b1;
        mem.write = 1'b1;
        mem.addr = req_addr;
        mem.wstrb = wstrb_q;
        mem.wdata = wdata_q;
        core.ready = mem.ready;
        state_d = mem.ready ? IDLE : WR_MEM;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef DCACHE_PERF_EN
  dcache_perf_cnt u_perf (
    .clk(clk),
    .rst(rst),
    .hit_i(state_q == LOOKUP && hit),
    .miss_i(state_q == LOOKUP && !hit),
    .hit_o(perf_hit_o),
    .miss_o(perf_miss_o)
  );
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed table, reset-mid-refill sequence and random traffic against a cache/memory reference model
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    int          beats;
    logic [15:0] web;
    string       nm;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  dcache_ctrl_if core_bus();
  dcache_ctrl_if mem_bus();
  logic da_cs, da_oe, ta_cs, ta_oe, ta_web;
  logic [15:0] da_web;
  logic [5:0] da_a, ta_a;
  logic [127:0] da_di, da_do;
  logic [21:0] ta_di, ta_do;
`ifdef DCACHE_PERF_EN
  logic [31:0] perf_hit, perf_miss;
`endif
  dcache_ctrl dut (
    .clk(clk),
    .rst(rst),
    .core(core_bus),
    .mem(mem_bus),
    .da_cs_o(da_cs),
    .da_oe_o(da_oe),
    .da_web_o(da_web),
    .da_a_o(da_a),
    .da_di_o(da_di),
    .da_do_i(da_do),
    .ta_cs_o(ta_cs),
    .ta_oe_o(ta_oe),
    .ta_web_o(ta_web),
    .ta_a_o(ta_a),
    .ta_di_o(ta_di),
    .ta_do_i(ta_do)
`ifdef DCACHE_PERF_EN
    ,
    .perf_hit_o(perf_hit),
    .perf_miss_o(perf_miss)
`endif
  );
  logic [127:0] da_mem [64];
  logic [21:0] ta_mem [64];
  always @(posedge clk) begin
    if (da_cs) begin
      for (int b = 0; b < 16; b++) if (!da_web[b]) da_mem[da_a][8*b +: 8] <= da_di[8*b +: 8];
      if (da_oe) da_do <= da_mem[da_a];
    end
    if (ta_cs) begin
      if (!ta_web) ta_mem[ta_a] <= ta_di;
      if (ta_oe) ta_do <= ta_mem[ta_a];
    end
  end
  int web_cnt = 0;
  logic [15:0] web_last = '1;
  always @(posedge clk)
    if (da_cs && da_web != '1) begin
      web_cnt <= web_cnt + 1;
      web_last <= da_web;
    end
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] rd_log [$];
  wr_t wr_log [$];
  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction
  initial begin
    int wait_cnt, dly;
    logic [31:0] v;
    wr_t w;
    mem_bus.ready = 1'b0;
    mem_bus.rdata = '0;
    wait_cnt = 0;
    dly = 0;
    forever begin
      @(negedge clk);
      mem_bus.ready = 1'b0;
      if (rst) wait_cnt = 0;
      else if (mem_bus.req) begin
        if (wait_cnt < dly) wait_cnt++;
        else begin
          wait_cnt = 0;
          dly = $urandom_range(0, 2);
          mem_bus.ready = 1'b1;
          if (mem_bus.write) begin
            v = mem_rd(mem_bus.addr);
            for (int b = 0; b < 4; b++) if (mem_bus.wstrb[b]) v[8*b +: 8] = mem_bus.wdata[8*b +: 8];
            mem_m[mem_bus.addr] = v;
            w.addr = mem_bus.addr;
            w.strb = mem_bus.wstrb;
            w.data = mem_bus.wdata;
            wr_log.push_back(w);
          end else begin
            mem_bus.rdata = mem_rd(mem_bus.addr);
            rd_log.push_back(mem_bus.addr);
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_bus.ready = 1'b1;
        mem_bus.rdata = $urandom;
      end
    end
  end
  int checks = 0, failures = 0;
  bit mv [64];
  logic [21:0] mt [64];
  int pf_hit = 0, pf_miss = 0;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  function automatic bit model_hit(logic [31:0] a);
    return mv[a[9:4]] && mt[a[9:4]] == a[31:10];
  endfunction
  task automatic run(input bit wr, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     input int eb, input logic [15:0] ew, input string nm);
    logic [31:0] exp_d, got;
    int lat, r0, w0, p0;
    bit done, h;
    h = model_hit(a);
    exp_d = mem_rd({a[31:2], 2'b00});
    r0 = rd_log.size();
    w0 = wr_log.size();
    p0 = web_cnt;
    got = '0;
    @(negedge clk);
    #1;
    core_bus.req = 1'b1;
    core_bus.write = wr;
    core_bus.addr = a;
    core_bus.wstrb = s;
    core_bus.wdata = d;
    lat = 1;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #1;
      lat++;
      if (core_bus.ready) begin
        done = 1'b1;
        got = core_bus.rdata;
      end
    end
    core_bus.req = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_completes"}, 128'(done), 128'(1));
    if (!wr) chk({nm, "_rdata"}, got, exp_d);
    if (!wr && eb == 0) chk({nm, "_hit_latency"}, lat, 2);
    chk({nm, "_read_beats"}, rd_log.size() - r0, eb);
    for (int i = 0; i < eb; i++)
      if (r0 + i < rd_log.size()) chk({nm, "_beat_addr"}, rd_log[r0+i], {a[31:4], 2'(i), 2'b00});
    chk({nm, "_mem_writes"}, wr_log.size() - w0, 32'(wr));
    if (wr && wr_log.size() > w0) begin
      chk({nm, "_wr_addr"}, wr_log[w0].addr, {a[31:2], 2'b00});
      chk({nm, "_wr_strb"}, wr_log[w0].strb, s);
      chk({nm, "_wr_data"}, wr_log[w0].data, d);
    end
    chk({nm, "_da_web"}, web_cnt != p0 ? web_last : 16'hFFFF, ew);
    if (h) pf_hit++;
    else pf_miss++;
    if (!wr) begin
      mv[a[9:4]] = 1'b1;
      mt[a[9:4]] = a[31:10];
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tv [10];
    int n0, eb;
    bit done, h, wr;
    logic [31:0] a, d;
    logic [3:0] s;
    logic [15:0] ew;
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    rst = 1'b1;
    core_bus.req = 1'b0;
    core_bus.write = 1'b0;
    core_bus.addr = '0;
    core_bus.wstrb = '0;
    core_bus.wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_core_ready", core_bus.ready, 0);
    chk("rst_core_rdata", core_bus.rdata, 0);
    chk("rst_mem_req", mem_bus.req, 0);
    chk("rst_mem_write", mem_bus.write, 0);
    chk("rst_mem_addr", mem_bus.addr, 0);
    chk("rst_da_web", da_web, 16'hFFFF);
    chk("rst_ta_web", ta_web, 1);
    chk("rst_da_cs", da_cs, 0);
    chk("rst_ta_cs", ta_cs, 0);
    @(negedge clk);
    rst = 1'b0;
    tv[0] = '{0, 32'h0000_0040, 4'h0, 32'h0, 4, 16'h0000, "t1_cold_load"};
    tv[1] = '{0, 32'h0000_0048, 4'h0, 32'h0, 0, 16'hFFFF, "t2_load_hit"};
    tv[2] = '{1, 32'h0000_0044, 4'b0011, 32'hA5A5_1234, 0, 16'hFFCF, "t3_store_hit"};
    tv[3] = '{0, 32'h0000_0044, 4'h0, 32'h0, 0, 16'hFFFF, "t3_reload_merged"};
    tv[4] = '{1, 32'h0000_1000, 4'hF, 32'hCAFE_F00D, 0, 16'hFFFF, "t4_store_miss"};
    tv[5] = '{0, 32'h0000_1000, 4'h0, 32'h0, 4, 16'h0000, "t4_load_after_store_miss"};
    tv[6] = '{0, 32'h0000_0440, 4'h0, 32'h0, 4, 16'h0000, "t5_conflict_refill"};
    tv[7] = '{0, 32'h0000_0040, 4'h0, 32'h0, 4, 16'h0000, "t5_evicted_reload"};
    tv[8] = '{1, 32'h0000_0040, 4'h0, 32'hFFFF_FFFF, 0, 16'hFFFF, "wstrb0_store_hit"};
    tv[9] = '{0, 32'h0000_0040, 4'h0, 32'h0, 0, 16'hFFFF, "after_wstrb0_load"};
    for (int i = 0; i < 10; i++) begin
      run(tv[i].wr, tv[i].addr, tv[i].strb, tv[i].data, tv[i].beats, tv[i].web, tv[i].nm);
      if (i == 3) chk("t3_merged_word", mem_rd(32'h44), (mem_rd(32'h44) & 32'hFFFF_0000) | 32'h1234);
      if (i == 6) chk("t5_tag_idx4", ta_mem[4], 22'h1);
    end
    n0 = rd_log.size();
    @(negedge clk);
    #1;
    core_bus.req = 1'b1;
    core_bus.write = 1'b0;
    core_bus.addr = 32'h0000_0840;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #1;
      if (rd_log.size() - n0 >= 2) done = 1'b1;
    end
    chk("t6_two_beats_seen", 128'(done), 128'(1));
    @(posedge clk);
    #2;
    chk("t6_mem_req_before_rst", mem_bus.req, 1);
    rst = 1'b1;
    #1;
    chk("t6_mem_req_drops", mem_bus.req, 0);
    chk("t6_core_ready_low", core_bus.ready, 0);
    chk("t6_da_web_idle", da_web, 16'hFFFF);
    core_bus.req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    pf_hit = 0;
    pf_miss = 0;
    run(0, 32'h0000_0040, 4'h0, 32'h0, 4, 16'h0000, "t6_refill_after_rst");
    run(0, 32'h0000_0840, 4'h0, 32'h0, 4, 16'h0000, "t6_aborted_line_misses");
    for (int n = 0; n < 300; n++) begin
      wr = $urandom_range(0, 2) == 0;
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) | (32'($urandom_range(0, 3)) << 2);
      s = 4'($urandom);
      d = $urandom;
      h = model_hit(a);
      eb = (!wr && !h) ? 4 : 0;
      for (int b = 0; b < 16; b++) ew[b] = !(wr && h && b / 4 == int'(a[3:2]) && s[b % 4]);
      if (!wr && !h) ew = '0;
      run(wr, a, s, d, eb, ew, $sformatf("rnd%0d", n));
    end
`ifdef DCACHE_PERF_EN
    chk("perf_hit", perf_hit, pf_hit);
    chk("perf_miss", perf_miss, pf_miss);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
